// File: rtl/pio_out_blink_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pio_out_blink_pkg
// Purpose  : Shared register map for the blinking output PIO.
//            Word offsets decoded by the top level and the register count.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pio_out_blink_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_SET       = 3'd1;
  localparam logic [2:0] ADDR_CLEAR     = 3'd2;
  localparam logic [2:0] ADDR_TOGGLE    = 3'd3;
  localparam logic [2:0] ADDR_BLINK_EN  = 3'd4;
  localparam logic [2:0] ADDR_BLINK_DIV = 3'd5;
  localparam logic [2:0] ADDR_STATUS    = 3'd6;

  // Offsets 0..7 are decoded; offset 7 is reserved.
  localparam int NUM_REGS = 8;

endpackage : pio_out_blink_pkg
`default_nettype wire

// File: rtl/pio_blink_timer.sv
`default_nettype none
// ============================================================================
// Module   : pio_blink_timer
// Purpose  : Blink prescaler. A down-counter reloads from div_in when it hits
//            zero and flips phase, giving a half-period of div_in+1 cycles.
// Ports    : clk      - system clock
//            reset    - synchronous active-high reset
//            restart  - reload counter from div_in and force phase to 0
//            load_div - new divider written; same effect as restart
//            div_in   - reload value (the new divider during load_div)
//            phase    - current blink phase
// Revision : 1.0 - initial release
// ============================================================================
module pio_blink_timer
  import pio_out_blink_pkg::*;
#(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 restart,
  input  logic                 load_div,
  input  logic [DIV_WIDTH-1:0] div_in,
  output logic                 phase
);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic                 r_phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (load_div || restart) begin
      r_cnt   <= div_in;
      r_phase <= 1'b0;
    end else if (r_cnt == '0) begin
      // Wrap through the reload value, never through underflow.
      r_cnt   <= div_in;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt - DIV_WIDTH'(1);
    end
  end

  assign phase = r_phase;

endmodule : pio_blink_timer
`default_nettype wire

// File: rtl/pio_out_blink.sv
`default_nettype none
// ============================================================================
// Module   : pio_out_blink
// Purpose  : Avalon-MM output PIO with atomic set/clear/toggle and per-bit
//            hardware blink. Zero wait states, combinational read data.
// Ports    : clk        - system clock
//            reset      - synchronous active-high reset (wins over writes)
//            address    - word offset
//            chipselect - slave select
//            write_n    - active-low write strobe
//            writedata  - write data, LSBs used
//            readdata   - combinational read data, zero-extended
//            out_port   - DATA ^ (BLINK_EN & phase)
// Revision : 1.0 - initial release
// ============================================================================
module pio_out_blink
  import pio_out_blink_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter int          DIV_WIDTH   = 16,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0]     r_data;
  logic [WIDTH-1:0]     r_blink_en;
  logic [DIV_WIDTH-1:0] r_blink_div;

  logic                 w_wr;
  logic [WIDTH-1:0]     w_wd;
  logic [DIV_WIDTH-1:0] w_wd_div;
  logic                 w_wr_en;
  logic                 w_wr_div;
  logic [DIV_WIDTH-1:0] w_div_in;
  logic                 w_phase;
  logic                 w_unused;

  assign w_wr     = chipselect && !write_n;
  assign w_wd     = writedata[WIDTH-1:0];
  assign w_wd_div = writedata[DIV_WIDTH-1:0];
  assign w_wr_en  = w_wr && (address == ADDR_BLINK_EN);
  assign w_wr_div = w_wr && (address == ADDR_BLINK_DIV);

  // Upper write-data bits are intentionally dropped.
  assign w_unused = ^writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data      <= RESET_VALUE[WIDTH-1:0];
      r_blink_en  <= '0;
      r_blink_div <= '0;
    end else if (w_wr) begin
      case (address)
        ADDR_DATA:      r_data      <= w_wd;
        ADDR_SET:       r_data      <= r_data | w_wd;
        ADDR_CLEAR:     r_data      <= r_data & ~w_wd;
        ADDR_TOGGLE:    r_data      <= r_data ^ w_wd;
        ADDR_BLINK_EN:  r_blink_en  <= w_wd;
        ADDR_BLINK_DIV: r_blink_div <= w_wd_div;
        default:        ;
      endcase
    end
  end

  // During a divider write the timer must reload from the incoming value,
  // not the stale register contents.
  assign w_div_in = w_wr_div ? w_wd_div : r_blink_div;

  pio_blink_timer #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .restart  (w_wr_en),
    .load_div (w_wr_div),
    .div_in   (w_div_in),
    .phase    (w_phase)
  );

  always_comb begin
    readdata = 32'h0;
    case (address)
      ADDR_DATA:      readdata = 32'(r_data);
      ADDR_BLINK_EN:  readdata = 32'(r_blink_en);
      ADDR_BLINK_DIV: readdata = 32'(r_blink_div);
      ADDR_STATUS:    readdata = {31'h0, w_phase};
      default:        readdata = 32'h0;
    endcase
  end

  assign out_port = r_data ^ (r_blink_en & {WIDTH{w_phase}});

endmodule : pio_out_blink
`default_nettype wire

// File: doc/pio_out_blink.md
Name: pio_out_blink

Overview:
Avalon-MM slave output port of parametrised width for board LEDs and GPIO outputs. It adds atomic bit set, clear and toggle registers. It also adds a per-bit hardware blink mode driven by a programmable prescaler, so software can flash outputs without polling. It connects to the system interconnect exactly as the simple output PIO does: zero wait states and zero read latency.

Parameters:
WIDTH, 8, output port width; legal range 1..32.
DIV_WIDTH, 16, width of the blink divider register and counter; legal range 1..32.
RESET_VALUE, 0, value of DATA after reset; only WIDTH LSBs are used.

Ports:
clk  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
address  in  3  word register offset.
chipselect  in  1  slave select.
write_n  in  1  active-low write strobe; a write is chipselect && !write_n.
writedata  in  32  write data; LSBs used.
readdata  out  32  combinational read data; unused MSBs are 0.
out_port  out  WIDTH  pin-facing output.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on reset. It takes effect at the next rising edge of clk and overrides any write in the same cycle.
- Values after reset:
  - DATA = RESET_VALUE
  - BLINK_EN = 0
  - BLINK_DIV = 0
  - cnt = 0
  - phase = 0
  - out_port = RESET_VALUE
- Register map (offset, access, function):
  - 0 DATA, RW: write loads writedata[WIDTH-1:0].
  - 1 SET, W: DATA <= DATA | wd. Reads 0.
  - 2 CLEAR, W: DATA <= DATA & ~wd. Reads 0.
  - 3 TOGGLE, W: DATA <= DATA ^ wd. Reads 0.
  - 4 BLINK_EN, RW: per-bit blink mask, WIDTH bits.
  - 5 BLINK_DIV, RW: prescaler reload value, DIV_WIDTH bits.
  - 6 STATUS, R: bit0 = phase; other bits 0. Writes ignored.
  - 7 reserved: reads 0, writes ignored.
- Write timing: a write accepted at edge N updates the register at edge N. out_port reflects the new value immediately after edge N, i.e. 1-cycle write-to-pin latency.
- Read timing: readdata is a pure function of address and current register state; no wait states. Reads have no side effects.
- Output equation: out_port = DATA ^ (BLINK_EN & {WIDTH{phase}}). With BLINK_EN = 0, out_port equals DATA exactly.
- Prescaler, evaluated each cycle when not in reset:
  - If a BLINK_DIV write occurs: BLINK_DIV <= wd, cnt <= wd[DIV_WIDTH-1:0], phase <= 0.
  - Else if a BLINK_EN write occurs: cnt <= BLINK_DIV, phase <= 0.
  - Else if cnt == 0: cnt <= BLINK_DIV, phase <= ~phase.
  - Else: cnt <= cnt - 1.
- Prescaler consequences:
  - Phase half-period is BLINK_DIV+1 cycles; full period is 2*(BLINK_DIV+1).
  - BLINK_DIV = 0 toggles phase every cycle.
  - Counter wrap uses the reload value, never underflow.
- The prescaler runs continuously regardless of BLINK_EN; only a BLINK_EN or BLINK_DIV write restarts it.
- Write-data width rules:
  - writedata bits above WIDTH (or above DIV_WIDTH for BLINK_DIV) are ignored.
  - Readback zero-extends to 32 bits.
- Simultaneous events: the interface allows at most one write per cycle. A SET/CLEAR/TOGGLE write in the same cycle as a prescaler tick applies to DATA; phase ticks independently.

Decomposition:
- Shared package holds:
  - address constants ADDR_DATA=0 through ADDR_STATUS=6
  - the register-count constant
- One sub-module, pio_blink_timer, contains cnt, phase, reload and restart logic. Its ports:
  - clk, reset
  - restart, load_div, div_in
  - phase out
- The top level holds DATA, BLINK_EN, BLINK_DIV, the write decode, the read mux and the output XOR.

Test Plan:
Bench configuration: WIDTH=8, DIV_WIDTH=4, RESET_VALUE=8'hA5.
- Reset: assert reset 2 cycles -> out_port=A5; reads of 0/4/5/6 return 000000A5/0/0/0.
- Atomic ops:
  - write DATA=0F -> out_port=0F next edge
  - SET F0 -> FF
  - CLEAR 3C -> C3
  - TOGGLE FF -> 3C
  - read offsets 1-3 return 0.
- Blink: DATA=00, BLINK_DIV=3, BLINK_EN=81 -> out_port alternates 00 for 4 cycles, 81 for 4 cycles, repeating; STATUS bit0 tracks phase.
- Divider zero and restart:
  - BLINK_DIV=0 with BLINK_EN=01 -> bit0 toggles every cycle.
  - Rewriting BLINK_EN mid-period forces phase=0 at that edge.
- Width masking: write DATA=FFFFFF12 -> read 00000012; write BLINK_DIV=FFFF -> read 0000000F.
- Reset mid-blink: assert reset while phase=1 and a TOGGLE write is in the same cycle -> out_port=A5, STATUS=0, blinking stopped.
